// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller:
// opcode classes, stage tags, forwarding codes and FSM states.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwr;
        logic       memrd;
        logic       memwr;
        logic       branch;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // EX/MEM result beats MEM/WB when both write the register.
    function automatic fwd_sel_t fwd_pick(
        input logic       m_regwr,
        input logic [4:0] m_rd,
        input logic       w_regwr,
        input logic [4:0] w_rd,
        input logic [4:0] rs
    );
        fwd_sel_t s;
        s = FWD_RF;
        if (m_regwr && m_rd != 5'd0 && m_rd == rs)
            s = FWD_MEM;
        else if (w_regwr && w_rd != 5'd0 && w_rd == rs)
            s = FWD_WB;
        return s;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// slave = controller, master = pipeline driving ID/EX/MEM status.
interface hazard_ctrl_if;

    logic [31:0] id_inst;
    logic        id_valid;
    logic        ex_branch_taken;
    logic        dmem_ready;
    logic        pc_we;
    logic        ifid_we;
    logic        idex_we;
    logic        exmem_we;
    logic        memwb_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    modport master (
        output id_inst, id_valid, ex_branch_taken, dmem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        input  ifid_flush, idex_flush, fwd_a, fwd_b
    );

    modport slave (
        input  id_inst, id_valid, ex_branch_taken, dmem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        output ifid_flush, idex_flush, fwd_a, fwd_b
    );

endinterface

// File: rtl/hazard_ctrl_decode.sv
// ID-stage tag decoder: classifies the IF/ID instruction.
// Unused register fields are zeroed so they never match.
module pipe_tag_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    output stage_tag_t  tag
);

    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       unused_funct;

    assign op  = id_inst[6:0];
    assign rd  = id_inst[11:7];
    assign rs1 = id_inst[19:15];
    assign rs2 = id_inst[24:20];
    assign unused_funct = ^{id_inst[31:25], id_inst[14:12]};

    // Map opcode class to reads, writes and memory/branch flags.
    always_comb begin
        tag = TAG_BUBBLE;
        if (id_valid) begin
            unique case (1'b1)
                (op == OP_R): begin
                    tag.valid = 1'b1;
                    tag.rs1   = rs1;
                    tag.rs2   = rs2;
                    tag.rd    = rd;
                    tag.regwr = 1'b1;
                end
                (op == OP_LOAD): begin
                    tag.valid = 1'b1;
                    tag.rs1   = rs1;
                    tag.rd    = rd;
                    tag.regwr = 1'b1;
                    tag.memrd = 1'b1;
                end
                (op == OP_STORE): begin
                    tag.valid = 1'b1;
                    tag.rs1   = rs1;
                    tag.rs2   = rs2;
                    tag.memwr = 1'b1;
                end
                (op == OP_BRANCH): begin
                    tag.valid  = 1'b1;
                    tag.rs1    = rs1;
                    tag.rs2    = rs2;
                    tag.branch = 1'b1;
                end
                default: tag = TAG_BUBBLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: tag pipeline, freeze FSM,
// branch flush, load-use stall, EX forwarding and counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     bus,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W =
        (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    stage_tag_t id_tag;
    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;
    hz_state_t  st_q;
    hz_state_t  st_d;
    logic [WC_W-1:0] wcnt_q;
    logic [WC_W-1:0] wcnt_d;

    logic freeze;
    logic flush;
    logic lu_stall;
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    logic unused_tags;

    pipe_tag_decode u_dec (
        .id_inst  (bus.id_inst),
        .id_valid (bus.id_valid),
        .tag      (id_tag)
    );

    assign unused_tags = ^{ex_q, mem_q, wb_q};

    assign freeze = !rst && mem_q.valid
                 && (mem_q.memrd || mem_q.memwr)
                 && !bus.dmem_ready;
    assign flush = !rst && !freeze
                && ex_q.branch && bus.ex_branch_taken;
    assign lu_stall = !rst && !freeze && !flush
                   && ex_q.memrd && ex_q.rd != 5'd0
                   && (ex_q.rd == id_tag.rs1
                    || ex_q.rd == id_tag.rs2);

    // Stage enables, flushes and forwarding by priority.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fwd_a = fwd_pick(mem_q.regwr, mem_q.rd,
                         wb_q.regwr, wb_q.rd, ex_q.rs1);
        fwd_b = fwd_pick(mem_q.regwr, mem_q.rd,
                         wb_q.regwr, wb_q.rd, ex_q.rs2);
        unique case (1'b1)
            rst: begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_we    = 1'b0;
                exmem_we   = 1'b0;
                memwb_we   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                fwd_a      = FWD_RF;
                fwd_b      = FWD_RF;
            end
            freeze: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
                memwb_we = 1'b0;
            end
            flush: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            lu_stall: begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_we      = pc_we;
    assign bus.ifid_we    = ifid_we;
    assign bus.idex_we    = idex_we;
    assign bus.exmem_we   = exmem_we;
    assign bus.memwb_we   = memwb_we;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;
    assign bus.fwd_a      = fwd_a;
    assign bus.fwd_b      = fwd_b;

    // Shadow tag pipeline; holds while data memory is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= TAG_BUBBLE;
            mem_q <= TAG_BUBBLE;
            wb_q  <= TAG_BUBBLE;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (flush || lu_stall) ? TAG_BUBBLE : id_tag;
        end
    end

    // Run/wait state register.
    always_ff @(posedge clk) begin
        if (rst) st_q <= ST_RUN;
        else     st_q <= st_d;
    end

    // Next state and wait-counter update.
    always_comb begin
        st_d   = st_q;
        wcnt_d = wcnt_q;
        unique case (st_q)
            ST_RUN: begin
                if (freeze) begin
                    st_d   = ST_MEM_WAIT;
                    wcnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!freeze)
                    st_d = ST_RUN;
                else if (wcnt_q != WC_MAX)
                    wcnt_d = wcnt_q + WC_W'(1);
            end
            default: st_d = ST_RUN;
        endcase
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            if (st_q == ST_MEM_WAIT && freeze
                && wcnt_d == WC_MAX)
                mem_timeout <= 1'b1;
        end
    end

    // Saturating count of cycles the PC is held.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (!pc_we && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios
// plus randomized traffic against an instruction-level model.
module tb_hazard_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int C_NONE = 0;
    localparam int C_ALU  = 1;
    localparam int C_LD   = 2;
    localparam int C_ST   = 3;
    localparam int C_BR   = 4;

    logic          clk;
    logic          rst;
    logic          mem_timeout;
    logic [CW-1:0] stall_cycles;
    int            checks;
    int            errors;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    wire [4:0] we_v = {bus.pc_we, bus.ifid_we, bus.idex_we,
                       bus.exmem_we, bus.memwb_we};
    wire [1:0] fl_v = {bus.ifid_flush, bus.idex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int rs1;
        int rs2;
        int rd;
    } minst_t;

    typedef struct {
        bit [4:0] we;
        bit [1:0] fl;
        bit [1:0] fa;
        bit [1:0] fb;
        bit       frz;
        bit       brf;
        bit       lu;
    } exp_t;

    minst_t m_ex, m_mem, m_wb;
    int     m_stall;
    bit     m_tmo;
    int     m_frz;
    exp_t   ex_e;

    function automatic logic [31:0] enc_add(int rd, int a, int b);
        return {7'd0, 5'(b), 5'(a), 3'd0, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(int rd, int a);
        return {12'd4, 5'(a), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(int b, int a);
        return {7'd0, 5'(b), 5'(a), 3'b010, 5'd8, 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_beq(int a, int b);
        return {7'd0, 5'(b), 5'(a), 3'b000, 5'd0, 7'b1100011};
    endfunction

    function automatic minst_t none_inst();
        minst_t r;
        r.cls = C_NONE; r.rs1 = -1; r.rs2 = -1; r.rd = -1;
        return r;
    endfunction

    // Register fields that are not used, or are x0, become -1.
    function automatic minst_t mdec(logic [31:0] inst, logic v);
        minst_t r;
        int op, rd, a, b;
        r  = none_inst();
        op = int'(inst[6:0]);
        rd = int'(inst[11:7]);
        a  = int'(inst[19:15]);
        b  = int'(inst[24:20]);
        if (v !== 1'b1) return r;
        case (op)
            'h33: begin r.cls = C_ALU; r.rs1 = a; r.rs2 = b; r.rd = rd; end
            'h03: begin r.cls = C_LD; r.rs1 = a; r.rd = rd; end
            'h23: begin r.cls = C_ST; r.rs1 = a; r.rs2 = b; end
            'h63: begin r.cls = C_BR; r.rs1 = a; r.rs2 = b; end
            default: ;
        endcase
        if (r.rs1 == 0) r.rs1 = -1;
        if (r.rs2 == 0) r.rs2 = -1;
        if (r.rd == 0)  r.rd  = -1;
        return r;
    endfunction

    function automatic bit [1:0] msrc(int rg);
        if (rg <= 0) return 2'b00;
        if (m_mem.rd == rg) return 2'b10;
        if (m_wb.rd == rg) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t meval(logic r, logic [31:0] inst,
                                   logic v, logic tk, logic rdy);
        exp_t   e;
        minst_t id;
        id = mdec(inst, v);
        e.frz = !r && (m_mem.cls == C_LD || m_mem.cls == C_ST)
             && (rdy == 1'b0);
        e.brf = !r && !e.frz && m_ex.cls == C_BR && (tk == 1'b1);
        e.lu  = !r && !e.frz && !e.brf && m_ex.cls == C_LD
             && m_ex.rd > 0
             && (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
        e.fa = 2'b00;
        e.fb = 2'b00;
        if (r) begin
            e.we = 5'b00000; e.fl = 2'b11;
        end else begin
            e.fa = msrc(m_ex.rs1);
            e.fb = msrc(m_ex.rs2);
            if (e.frz) begin
                e.we = 5'b00000; e.fl = 2'b00;
            end else if (e.brf) begin
                e.we = 5'b11111; e.fl = 2'b11;
            end else if (e.lu) begin
                e.we = 5'b00111; e.fl = 2'b01;
            end else begin
                e.we = 5'b11111; e.fl = 2'b00;
            end
        end
        return e;
    endfunction

    // Instruction-level reference: advance on every clock edge.
    always @(posedge clk) begin : model
        exp_t e;
        e = meval(rst, bus.id_inst, bus.id_valid,
                  bus.ex_branch_taken, bus.dmem_ready);
        if (rst) begin
            m_ex    <= none_inst();
            m_mem   <= none_inst();
            m_wb    <= none_inst();
            m_stall <= 0;
            m_tmo   <= 1'b0;
            m_frz   <= 0;
        end else begin
            if (!e.frz) begin
                m_wb  <= m_mem;
                m_mem <= m_ex;
                if (e.brf || e.lu) m_ex <= none_inst();
                else m_ex <= mdec(bus.id_inst, bus.id_valid);
            end
            if ((e.frz || e.lu) && m_stall < (1 << CW) - 1)
                m_stall <= m_stall + 1;
            if (e.frz) begin
                m_frz <= m_frz + 1;
                if (m_frz + 1 >= TMO + 1) m_tmo <= 1'b1;
            end else begin
                m_frz <= 0;
            end
        end
    end

    task automatic cyc(input logic r, input logic [31:0] inst,
                       input logic v, input logic tk,
                       input logic rdy);
        @(negedge clk);
        rst                 = r;
        bus.id_inst         = inst;
        bus.id_valid        = v;
        bus.ex_branch_taken = tk;
        bus.dmem_ready      = rdy;
        #1;
        ex_e = meval(r, inst, v, tk, rdy);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        repeat (2) cyc(1'b1, NOP, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (we_v !== 5'b00000) begin errors++; $display("FAIL rst_we got=%b exp=00000", we_v); end
        checks++; if (fl_v !== 2'b11) begin errors++; $display("FAIL rst_flush got=%b exp=11", fl_v); end
        checks++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got=%b%b exp=0000", bus.fwd_a, bus.fwd_b); end
        idle(1);
        checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_tmo got=%b exp=0", mem_timeout); end
        checks++; if (we_v !== 5'b11111) begin errors++; $display("FAIL rst_run_we got=%b exp=11111", we_v); end
    endtask

    task automatic test_fwd();
        idle(3);
        cyc(1'b0, enc_add(3, 1, 2), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_add(5, 3, 4), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_add(6, 3, 0), 1'b1, 1'b0, 1'b1);
        checks++; if (bus.fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_exmem_a got=%b exp=10", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_exmem_b got=%b exp=00", bus.fwd_b); end
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_memwb_a got=%b exp=01", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_x0_b got=%b exp=00", bus.fwd_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        idle(2);
        cyc(1'b0, enc_lw(3, 1), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_add(5, 3, 4), 1'b1, 1'b0, 1'b1);
        checks++; if (we_v !== 5'b00111) begin errors++; $display("FAIL lu_we got=%b exp=00111", we_v); end
        checks++; if (fl_v !== 2'b01) begin errors++; $display("FAIL lu_flush got=%b exp=01", fl_v); end
        cyc(1'b0, enc_add(5, 3, 4), 1'b1, 1'b0, 1'b1);
        checks++; if (we_v !== 5'b11111) begin errors++; $display("FAIL lu_once got=%b exp=11111", we_v); end
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwd got=%b exp=01", bus.fwd_a); end
        checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_branch();
        idle(3);
        cyc(1'b0, enc_add(3, 1, 2), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_beq(3, 3), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_add(6, 3, 3), 1'b1, 1'b1, 1'b1);
        checks++; if (fl_v !== 2'b11) begin errors++; $display("FAIL br_flush got=%b exp=11", fl_v); end
        checks++; if (we_v !== 5'b11111) begin errors++; $display("FAIL br_we got=%b exp=11111", we_v); end
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
        checks++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin errors++; $display("FAIL br_squash_fwd got=%b%b exp=0000", bus.fwd_a, bus.fwd_b); end
        checks++; if (fl_v !== 2'b00) begin errors++; $display("FAIL br_one_cycle got=%b exp=00", fl_v); end
        cyc(1'b0, NOP, 1'b1, 1'b1, 1'b1);
        checks++; if (fl_v !== 2'b00) begin errors++; $display("FAIL br_nobranch got=%b exp=00", fl_v); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        cyc(1'b0, enc_add(3, 1, 2), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_lw(5, 6), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_add(7, 3, 0), 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
            checks++; if (we_v !== 5'b00000) begin errors++; $display("FAIL mw_we k=%0d got=%b exp=00000", k, we_v); end
            checks++; if (fl_v !== 2'b00) begin errors++; $display("FAIL mw_flush k=%0d got=%b exp=00", k, fl_v); end
            checks++; if (bus.fwd_a !== 2'b01) begin errors++; $display("FAIL mw_fwd k=%0d got=%b exp=01", k, bus.fwd_a); end
        end
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
        checks++; if (we_v !== 5'b11111) begin errors++; $display("FAIL mw_adv got=%b exp=11111", we_v); end
        checks++; if (stall_cycles !== 4'd3) begin errors++; $display("FAIL mw_count got=%0d exp=3", stall_cycles); end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(1'b0, enc_lw(1, 2), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
            checks++; if (mem_timeout !== (k > TMO + 1)) begin errors++; $display("FAIL tmo_wait k=%0d got=%b exp=%b", k, mem_timeout, k > TMO + 1); end
        end
        idle(3);
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", mem_timeout); end
        do_reset();
        idle(1);
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got=%b exp=0", mem_timeout); end
    endtask

    task automatic test_x0();
        idle(3);
        cyc(1'b0, enc_add(0, 1, 2), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_add(5, 0, 0), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
        checks++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin errors++; $display("FAIL x0_fwd got=%b%b exp=0000", bus.fwd_a, bus.fwd_b); end
        cyc(1'b0, enc_lw(0, 1), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, enc_add(5, 0, 0), 1'b1, 1'b0, 1'b1);
        checks++; if (we_v !== 5'b11111) begin errors++; $display("FAIL x0_nostall got=%b exp=11111", we_v); end
    endtask

    task automatic test_reset_mid_wait();
        idle(3);
        cyc(1'b0, enc_lw(2, 1), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b1);
        repeat (7) cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, NOP, 1'b1, 1'b0, 1'b0);
        checks++; if (we_v !== 5'b00000 || fl_v !== 2'b11) begin errors++; $display("FAIL rm_during got=%b/%b exp=00000/11", we_v, fl_v); end
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
        checks++; if (we_v !== 5'b11111) begin errors++; $display("FAIL rm_run got=%b exp=11111", we_v); end
        checks++; if (stall_cycles !== 4'd0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL rm_counters got=%0d/%b exp=0/0", stall_cycles, mem_timeout); end
    endtask

    task automatic test_random();
        logic [31:0] inst;
        logic        r, v, tk, rdy;
        int          lowrun;
        lowrun = 0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 5))
                0: inst = enc_add($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: inst = enc_lw($urandom_range(0, 3), $urandom_range(0, 3));
                2: inst = enc_sw($urandom_range(0, 3), $urandom_range(0, 3));
                3: inst = enc_beq($urandom_range(0, 3), $urandom_range(0, 3));
                4: inst = NOP;
                default: inst = $urandom;
            endcase
            r  = ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 7) != 0);
            tk = $urandom_range(0, 1) == 1;
            if (lowrun == 0 && $urandom_range(0, 39) == 0)
                lowrun = $urandom_range(3, 8);
            if (lowrun > 0) begin
                rdy = 1'b0;
                lowrun--;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            cyc(r, inst, v, tk, rdy);
            checks++; if (we_v !== ex_e.we) begin errors++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, we_v, ex_e.we); end
            checks++; if (fl_v !== ex_e.fl) begin errors++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, fl_v, ex_e.fl); end
            checks++; if (bus.fwd_a !== ex_e.fa || bus.fwd_b !== ex_e.fb) begin errors++; $display("FAIL rnd_fwd n=%0d got=%b/%b exp=%b/%b", n, bus.fwd_a, bus.fwd_b, ex_e.fa, ex_e.fb); end
            checks++; if (stall_cycles !== CW'(m_stall)) begin errors++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall_cycles, m_stall); end
            checks++; if (mem_timeout !== m_tmo) begin errors++; $display("FAIL rnd_tmo n=%0d got=%b exp=%b", n, mem_timeout, m_tmo); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.id_inst = NOP;
        bus.id_valid = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.dmem_ready = 1'b1;
        test_reset();
        test_fwd();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_x0();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It shadows the ID→EX→MEM→WB flow with its own tag pipeline and drives the stage-register write enables, flushes and EX operand-forwarding selects. It resolves load-use stalls, taken-branch flushes and data-memory wait states. It sits beside the per-stage control decoder and consumes the same opcode classes (R-type, load, store, branch).

## Interface
- MEM_TIMEOUT, 255: wait cycles in MEM_WAIT before `mem_timeout` is set.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_inst  in  32  instruction currently in the IF/ID register.
- id_valid  in  1  `id_inst` holds a real instruction; 0 means bubble.
- ex_branch_taken  in  1  branch comparator result for the instruction in EX.
- dmem_ready  in  1  data memory completes the access presented in MEM this cycle.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  stage-register write enables.
- ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID or ID/EX.
- fwd_a, fwd_b  out  2 each  EX operand source: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- mem_timeout  out  1  sticky; cleared only by reset.
- stall_cycles  out  CNT_W  saturating count of cycles with `pc_we` = 0.

## Operation
- **ID decode** uses `id_inst[6:0]`:
  - 0110011: reads rs1 and rs2, writes rd.
  - 0000011: reads rs1, writes rd, memrd.
  - 0100011: reads rs1 and rs2, memwr.
  - 1100011: reads rs1 and rs2, branch.
  - Any other opcode, or `id_valid` = 0: bubble, with no reads or writes.
  - A register read or write of x0 never counts for hazards.
- **Tag pipeline.** Each of the ex, mem and wb tags holds {valid, rs1, rs2, rd, regwr, memrd, memwr, branch}.
  - On advance: wb ← mem, mem ← ex, ex ← ID decode (or a bubble when stalling or flushing).
- **Freeze.** Active when `mem.valid` and (`mem.memrd` or `mem.memwr`) and `!dmem_ready`.
  - All five write enables are 0, both flushes are 0, and the tags hold.
- **Branch flush.** Active when not frozen, `ex.branch` and `ex_branch_taken` are set.
  - `ifid_flush` = `idex_flush` = 1.
  - All write enables are 1.
  - The ex tag becomes a bubble.
  - `ex_branch_taken` is ignored when `ex.branch` = 0.
- **Load-use stall.** Active when not frozen, there is no flush, `ex.memrd` is set, `ex.rd` ≠ 0, and `ex.rd` equals a register the ID instruction reads.
  - `pc_we` = `ifid_we` = 0 and `idex_flush` = 1.
  - `idex_we`, `exmem_we`, `memwb_we` = 1.
  - The ex tag becomes a bubble.
- **Normal.** All enables are 1 and both flushes are 0.
- **Priority:** freeze > branch flush > load-use > normal.
- **Forwarding** (fwd_a uses `ex.rs1`; fwd_b uses `ex.rs2`):
  - 10 if `mem.regwr` is set, `mem.rd` ≠ 0 and `mem.rd` matches.
  - Otherwise 01 if `wb.regwr` is set, `wb.rd` ≠ 0 and `wb.rd` matches.
  - Otherwise 00. EX/MEM wins when both match.
  - The forwarding selects stay valid during a freeze.
- **FSM:** RUN ↔ MEM_WAIT.
  - RUN → MEM_WAIT on a freeze cycle.
  - MEM_WAIT → RUN on the cycle `dmem_ready` = 1; that cycle is already non-frozen and advances.
  - The wait counter resets on entry to MEM_WAIT.
  - `mem_timeout` is set when the counter reaches MEM_TIMEOUT.
  - The pipeline keeps waiting after a timeout; there is no forced advance.
- **stall_cycles** increments on every cycle with `pc_we` = 0 (freeze or load-use) and saturates at all-ones.

## Timing
- Every output except the counters is combinational from the registered tags, the FSM state, `id_inst`, `id_valid`, `ex_branch_taken` and `dmem_ready`. Added latency is zero.
- The load-use stall lasts exactly 1 cycle per hazard. The next cycle the load is in MEM and forwarding supplies the data via 01 one cycle later.
- A branch flush is 1 cycle. If a freeze overlaps a taken branch, the flush is deferred to the first non-frozen cycle; EX holds the branch and `ex_branch_taken` stays stable.
- **While `rst` = 1:**
  - All write enables are 0.
  - `ifid_flush` = `idex_flush` = 1.
  - `fwd_a` = `fwd_b` = 00.
- **On the reset edge:**
  - All tags are set invalid.
  - The FSM goes to RUN.
  - The wait counter, `stall_cycles` and `mem_timeout` are cleared.
- Reset asserted mid-MEM_WAIT or mid-stall abandons the operation immediately.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the opcode constants (OP_R, OP_LOAD, OP_STORE, OP_BRANCH);
  - the `stage_tag_t` struct;
  - the `fwd_sel_t` encoding;
  - the `hz_state_t` enum.
- One sub-module, `pipe_tag_decode`: combinational `id_inst` + `id_valid` → `stage_tag_t`. The top level holds the tags, FSM, priority logic and counters.

## Test plan
- add x3 ← x1,x2 then add x5 ← x3,x4 back-to-back → with the second add in EX, `fwd_a` = 10; a third instruction reading x3 gets `fwd_a` = 01 in EX.
- lw x3 then add x5 ← x3,x4 → exactly one cycle with `pc_we` = 0, `ifid_we` = 0, `idex_flush` = 1; next add-in-EX cycle has `fwd_a` = 01; `stall_cycles` = 1.
- beq in EX with `ex_branch_taken` = 1 → `ifid_flush` = `idex_flush` = 1 for one cycle; the following ex tag is invalid, so no forwarding from the squashed instruction.
- lw in MEM with `dmem_ready` low for 3 cycles → all enables 0 for 3 cycles, FSM in MEM_WAIT, `stall_cycles` = 3, advance on the 4th cycle.
- MEM_TIMEOUT = 4, `dmem_ready` held low for 6 cycles → `mem_timeout` rises on the 5th wait cycle and stays 1 after ready returns, until `rst`.
- add writing x0 followed by a dependent read of x0 → `fwd` = 00, no stall; `rst` asserted during MEM_WAIT → next cycle RUN, counters 0.
